wb_bram_burst: RTL and testbench

Wishbone B4 slave block RAM with real storage and per-byte write enables. Supports classic, constant-address and incrementing bursts, including linear and wrap-4/8/16 sequencing, with one ack per clock once a read burst is primed. It sits behind the memory controller's Wishbone interconnect as the generalised, storage-backed successor of the ack-only BRAM stub. It is used for on-chip frame and line buffers.

---
 rtl/wb_bram_burst.sv | 137 +++++++++++++
 tb/tb_wb_bram_burst.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram_burst.sv
// Wishbone B4 slave block RAM with per-byte write enables.
// Writes complete in the same cycle. Reads go through a synchronous BRAM,
// either as classic two-cycle reads or as primed bursts that return one
// beat per clock. Bursts can be constant-address, linear, or wrap-4/8/16.
module wb_bram_burst #(
    parameter int mem_adr_width = 11,
    parameter int data_width    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             adr,
    input  logic [data_width-1:0]   dat_ms,
    output logic [data_width-1:0]   dat_sm,
    input  logic [data_width/8-1:0] sel,
    input  logic                    we,
    input  logic                    stb,
    input  logic                    cyc,
    input  logic [2:0]              cti,
    input  logic [1:0]              bte,
    output logic                    ack,
    output logic                    err,
    output logic                    rty,
    output logic [1:0]              fsm_state
);

    localparam int nb    = data_width / 8;
    localparam int lb    = $clog2(nb);
    localparam int aw    = mem_adr_width;
    localparam int depth = 1 << mem_adr_width;

    // Handshake: a beat transfers in any cycle where stb and ack are both high.
    // A write acks in the same cycle it is presented. A read acks once the
    // BRAM output register holds the addressed word. stb alone frames the
    // cycle, so cyc is not needed.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLS   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t                state;
    logic [aw-1:0]         cur;
    logic [aw-1:0]         next_cur;
    logic [aw-1:0]         wrap_mask;
    logic [aw-1:0]         adr_word;
    logic [aw-1:0]         rd_addr;
    logic [data_width-1:0] mem [depth];
    logic [data_width-1:0] rd_q;
    logic                  cti_burst;
    logic                  cti_ok;
    logic                  wr_en;
    logic                  burst_hit;
    logic                  unused;

    assign adr_word  = adr[aw+lb-1:lb];
    assign cti_burst = (cti == 3'b001) || (cti == 3'b010);
    assign cti_ok    = cti_burst || (cti == 3'b111);

    // Reset overrides every ack source, including the write term.
    assign wr_en     = stb & we & ~rst;
    assign burst_hit = (state == BURST) & stb & ~we & (adr_word == cur) & cti_ok & ~rst;
    assign ack       = wr_en | ((state == CLS) & ~rst) | burst_hit;

    assign err       = 1'b0;
    assign rty       = 1'b0;
    assign dat_sm    = rd_q;
    assign fsm_state = state;
    assign unused    = ^{cyc, adr};

    // Compute the next burst index. Wrap modes advance only the low bits
    // selected by the mask. Linear mode uses an all-ones mask, so the index
    // rolls over modulo depth.
    always_comb begin
        wrap_mask = '1;
        case (bte)
            2'b01:   wrap_mask = aw'(3);
            2'b10:   wrap_mask = aw'(7);
            2'b11:   wrap_mask = aw'(15);
            default: wrap_mask = '1;
        endcase
        if (cti == 3'b001) next_cur = cur;
        else               next_cur = (cur & ~wrap_mask) | ((cur + aw'(1)) & wrap_mask);
    end

    // Choose the BRAM read address. An accepted beat fetches the next
    // index so the following cycle can ack again. A stalled burst re-reads
    // its current index. Otherwise the address comes from the bus.
    always_comb begin
        if (state == BURST) rd_addr = burst_hit ? next_cur : cur;
        else                rd_addr = adr_word;
    end

    // Storage: byte-lane writes plus a registered read port. Never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < nb; i++) begin
                if (sel[i]) mem[adr_word][i*8 +: 8] <= dat_ms[i*8 +: 8];
            end
        end
        rd_q <= mem[rd_addr];
    end

    // Read sequencer: classic reads take one wait cycle. Bursts track the
    // expected beat index and drop back to IDLE on any request they cannot
    // serve in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stb && !we) begin
                        if (cti_burst) begin
                            state <= BURST;
                            cur   <= adr_word;
                        end else begin
                            state <= CLS;
                        end
                    end
                end
                CLS: state <= IDLE;
                BURST: begin
                    if (burst_hit) begin
                        if (cti == 3'b111) state <= IDLE;
                        else               cur   <= next_cur;
                    end else if (stb) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: a vector table for writes and classic
// reads, then hand-written burst, stall, mismatch and reset sequences.
module tb_wb_bram_burst;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   adr;
    logic [DW-1:0] dat_ms;
    logic [DW-1:0] dat_sm;
    logic [NB-1:0] sel;
    logic          we;
    logic          stb;
    logic          cyc;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic          err;
    logic          rty;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic        exp_ack;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    // Clock/reset block
    always #5 clk = ~clk;

    wb_bram_burst #(.mem_adr_width(AW), .data_width(DW)) dut (
        .clk(clk), .rst(rst), .adr(adr), .dat_ms(dat_ms), .dat_sm(dat_sm),
        .sel(sel), .we(we), .stb(stb), .cyc(cyc), .cti(cti), .bte(bte),
        .ack(ack), .err(err), .rty(rty), .fsm_state(fsm_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: apply one bus cycle's inputs, then let combinational outputs settle.
    task automatic drive(input logic s, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] sl,
                         input logic [2:0] c, input logic [1:0] b);
        stb = s; cyc = s; we = w; adr = a; dat_ms = d; sel = sl; cti = c; bte = b;
        #1;
    endtask

    task automatic idle_bus();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    endtask

    // One full burst. The master holds each address until it is acked and
    // marks the final beat with cti=111.
    task automatic burst(input string tag, input int n, input int seq[16],
                         input logic [2:0] mode, input logic [1:0] b);
        logic [DW-1:0] e;
        for (int k = 0; k < n; k++) exp_q.push_back(DW'(seq[k]));
        drive(1'b1, 1'b0, 32'(seq[0]) << 2, 32'h0, 4'h0, mode, b);
        check({tag, " req ack"}, ack, 0);
        step();
        for (int k = 0; k < n; k++) begin
            drive(1'b1, 1'b0, 32'(seq[k]) << 2, 32'h0, 4'h0, (k == n - 1) ? 3'b111 : mode, b);
            e = exp_q.pop_front();
            check($sformatf("%s beat%0d ack", tag, k), ack, 1);
            check($sformatf("%s beat%0d dat", tag, k), dat_sm, e);
            step();
        end
        idle_bus();
        check({tag, " end ack"}, ack, 0);
        check({tag, " end state"}, fsm_state, 0);
        step();
    endtask

    task automatic classic_read(input string tag, input int word, input logic [31:0] exp);
        drive(1'b1, 1'b0, 32'(word) << 2, 32'h0, 4'h0, 3'b000, 2'b00);
        check({tag, " wait ack"}, ack, 0);
        step();
        check({tag, " ack"}, ack, 1);
        check({tag, " dat"}, dat_sm, exp);
        step();
        idle_bus();
        step();
    endtask

    initial begin
        int s[16];

        //                stb   we    adr          dat            sel   cti     ack   chk   exp
        vecs[0]  = '{1'b1, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 3'b000, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 3'b000, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 3'b000, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 3'b000, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 3'b000, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b1, 32'h20,   32'h11223344, 4'hF, 3'b000, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 3'b010, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h20,   32'h0,        4'h0, 3'b000, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h20,   32'h0,        4'h0, 3'b000, 1'b1, 1'b1, 32'h11BB33DD};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 3'b000, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 3'b111, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 3'b111, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 1'b0, 32'h20,   32'h0,        4'h0, 3'b011, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 32'h20,   32'h0,        4'h0, 3'b011, 1'b1, 1'b1, 32'h11BB33DD};
        vecs[14] = '{1'b1, 1'b1, 32'h10,   32'h0,        4'h0, 3'b000, 1'b1, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 3'b000, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'h0, 3'b000, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[17] = '{1'b1, 1'b0, 32'h2010, 32'h0,        4'h0, 3'b000, 1'b0, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 1'b0, 32'h2010, 32'h0,        4'h0, 3'b000, 1'b1, 1'b1, 32'hDEADBEEF};

        rst = 1'b1;
        idle_bus();
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("reset ack", ack, 0);
        check("reset state", fsm_state, 0);
        check("err tied", err, 0);
        check("rty tied", rty, 0);

        // Table: writes, partial writes, classic reads, aliasing
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stb, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].cti, 2'b00);
            check($sformatf("vec%0d ack", i), ack, vecs[i].exp_ack);
            if (vecs[i].chk_dat) check($sformatf("vec%0d dat", i), dat_sm, vecs[i].exp_dat);
            step();
        end
        idle_bus();
        step();

        // Preload words 0..31 with their own index
        for (int w = 0; w < 32; w++) begin
            drive(1'b1, 1'b1, 32'(w) << 2, 32'(w), 4'hF, 3'b000, 2'b00);
            check($sformatf("preload%0d ack", w), ack, 1);
            step();
        end
        idle_bus();
        step();

        s = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        burst("lin8", 8, s, 3'b010, 2'b00);
        s = '{6, 7, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        burst("wrap4", 4, s, 3'b010, 2'b01);
        s = '{13, 14, 15, 8, 9, 10, 11, 12, 0, 0, 0, 0, 0, 0, 0, 0};
        burst("wrap8", 8, s, 3'b010, 2'b10);
        s = '{30, 31, 16, 17, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        burst("wrap16", 5, s, 3'b010, 2'b11);
        s = '{9, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        burst("const", 3, s, 3'b001, 2'b00);

        // Stall: stb low for two cycles after beat 3, then continue with beat 4
        for (int k = 20; k < 26; k++) exp_q.push_back(DW'(k));
        drive(1'b1, 1'b0, 32'(20) << 2, 32'h0, 4'h0, 3'b010, 2'b00);
        check("stall req ack", ack, 0);
        step();
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                for (int g = 0; g < 2; g++) begin
                    drive(1'b0, 1'b0, 32'(24) << 2, 32'h0, 4'h0, 3'b010, 2'b00);
                    check($sformatf("stall gap%0d ack", g), ack, 0);
                    check($sformatf("stall gap%0d state", g), fsm_state, 2);
                    step();
                end
            end
            drive(1'b1, 1'b0, 32'(20 + k) << 2, 32'h0, 4'h0, (k == 5) ? 3'b111 : 3'b010, 2'b00);
            check($sformatf("stall beat%0d ack", k), ack, 1);
            check($sformatf("stall beat%0d dat", k), dat_sm, exp_q.pop_front());
            step();
        end
        idle_bus();
        check("stall end ack", ack, 0);
        step();

        // Address mismatch mid-burst restarts from IDLE
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b010, 2'b00);
        check("mis req ack", ack, 0);
        step();
        check("mis beat0 ack", ack, 1);
        check("mis beat0 dat", dat_sm, 0);
        step();
        drive(1'b1, 1'b0, 32'(5) << 2, 32'h0, 4'h0, 3'b010, 2'b00);
        check("mis jump ack", ack, 0);
        step();
        check("mis restart ack", ack, 0);
        check("mis restart state", fsm_state, 0);
        step();
        drive(1'b1, 1'b0, 32'(5) << 2, 32'h0, 4'h0, 3'b111, 2'b00);
        check("mis beat ack", ack, 1);
        check("mis beat dat", dat_sm, 5);
        step();
        idle_bus();
        step();

        // Reset on beat 2 of a burst; memory must be untouched
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b010, 2'b00);
        step();
        check("rstb beat0 ack", ack, 1);
        step();
        drive(1'b1, 1'b0, 32'(1) << 2, 32'h0, 4'h0, 3'b010, 2'b00);
        check("rstb beat1 ack", ack, 1);
        check("rstb beat1 dat", dat_sm, 1);
        step();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'(2) << 2, 32'h0, 4'h0, 3'b010, 2'b00);
        step();
        rst = 1'b0;
        idle_bus();
        check("rstb after ack", ack, 0);
        check("rstb after state", fsm_state, 0);
        step();
        for (int w = 0; w < 4; w++) classic_read($sformatf("rstb rd%0d", w), w, 32'(w));

        // Write during a burst is acked immediately and ends the burst
        drive(1'b1, 1'b0, 32'(30) << 2, 32'h0, 4'h0, 3'b010, 2'b00);
        step();
        check("wib beat0 ack", ack, 1);
        check("wib beat0 dat", dat_sm, 30);
        step();
        drive(1'b1, 1'b1, 32'(31) << 2, 32'h33, 4'hF, 3'b010, 2'b00);
        check("wib write ack", ack, 1);
        step();
        idle_bus();
        check("wib state", fsm_state, 0);
        step();
        classic_read("wib rd", 31, 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
